// File: rtl/reg_file_16bit_pkg.sv
// Shared datapath definitions for the register file and its consumers.
// Holds the default data/address widths, register index names, the
// operand-select mux encoding used downstream, and a sign-extend helper
// for the immediate path that shares that mux.
package reg_file_16bit_pkg;

  localparam int DP_DATA_W   = 16;
  localparam int DP_ADDR_W   = 3;
  localparam int DP_NUM_REGS = 2 ** DP_ADDR_W;
  localparam int CNT_W       = 8;

  typedef enum logic [DP_ADDR_W-1:0] {
    REG_ZERO = 3'd0,
    R1       = 3'd1,
    R2       = 3'd2,
    R3       = 3'd3,
    R4       = 3'd4,
    R5       = 3'd5,
    R6       = 3'd6,
    R7       = 3'd7
  } reg_idx_e;

  // Operand-select mux: X input is read port B, Y input is the immediate.
  typedef enum logic {
    SEL_REG = 1'b0,
    SEL_IMM = 1'b1
  } opsel_e;

  function automatic logic [DP_DATA_W-1:0] sext8(input logic [7:0] imm);
    return {{(DP_DATA_W-8){imm[7]}}, imm};
  endfunction

endpackage

// File: rtl/reg_file_16bit_if.sv
// Register file bus: one write port, two read ports and the write counter.
//   master : drives we/waddr/wdata/raddr_a/raddr_b, samples rdata_a/rdata_b/wr_count
//   slave  : the register file side
interface reg_file_16bit_if
  import reg_file_16bit_pkg::*;
#(
  parameter int DATA_W = DP_DATA_W,
  parameter int ADDR_W = DP_ADDR_W
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] raddr_a;
  logic [ADDR_W-1:0] raddr_b;
  logic [DATA_W-1:0] rdata_a;
  logic [DATA_W-1:0] rdata_b;
  logic [CNT_W-1:0]  wr_count;

  modport master (
    output we, waddr, wdata, raddr_a, raddr_b,
    input  rdata_a, rdata_b, wr_count
  );

  modport slave (
    input  we, waddr, wdata, raddr_a, raddr_b,
    output rdata_a, rdata_b, wr_count
  );
endinterface

// File: rtl/reg_file_16bit_reg16_en.sv
// reg16_en: DATA_W-bit register, asynchronous active-low clear, synchronous
// load enable.
//   clk   : rising-edge clock
//   rst_n : async clear, active low
//   en    : load d on the next rising edge
//   d/q   : data in / stored value
module reg16_en
  import reg_file_16bit_pkg::*;
#(
  parameter int DATA_W = DP_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (en) q <= d;
  end
endmodule

// File: rtl/reg_file_16bit.sv
// reg_file_16bit: 8 x 16-bit register file, R0 hardwired to zero.
//   clk   : rising-edge clock
//   rst_n : async active-low reset; clears R1..R7 and wr_count, forces reads to 0
//   bus   : slave side of reg_file_16bit_if (write port, read ports A/B, wr_count)
// Reads are combinational. With BYPASS=1 a write in flight is forwarded to
// any read port addressing the same register.
module reg_file_16bit
  import reg_file_16bit_pkg::*;
#(
  parameter int DATA_W = DP_DATA_W,
  parameter int ADDR_W = DP_ADDR_W,
  parameter bit BYPASS = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  reg_file_16bit_if.slave  bus
);
  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [NUM_REGS-1:0][DATA_W-1:0] q;
  logic [NUM_REGS-1:0]             ld;
  logic                            wr_ok;
  logic [CNT_W-1:0]                cnt;

  // A write to R0 is a no-op everywhere: storage, counter and bypass.
  assign wr_ok = bus.we && (bus.waddr != '0);

  assign q[0]  = '0;
  assign ld[0] = 1'b0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
    assign ld[i] = wr_ok && (bus.waddr == ADDR_W'(i));
    reg16_en #(.DATA_W(DATA_W)) u_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (ld[i]),
      .d     (bus.wdata),
      .q     (q[i])
    );
  end

  function automatic logic [DATA_W-1:0] rd_sel(
    input logic                            live,
    input logic [ADDR_W-1:0]               ra,
    input logic                            byp_hit,
    input logic [DATA_W-1:0]               wd,
    input logic [NUM_REGS-1:0][DATA_W-1:0] regs
  );
    // Reset gates the bypass too, so a write held during reset never leaks out.
    if (!live || ra == '0) return '0;
    if (BYPASS && byp_hit) return wd;
    return regs[ra];
  endfunction

  always_comb begin
    bus.rdata_a = rd_sel(rst_n, bus.raddr_a, wr_ok && (bus.raddr_a == bus.waddr), bus.wdata, q);
    bus.rdata_b = rd_sel(rst_n, bus.raddr_b, wr_ok && (bus.raddr_b == bus.waddr), bus.wdata, q);
  end

  // Saturating commit counter; holds at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   cnt <= '0;
    else if (wr_ok && ~&cnt)      cnt <= cnt + 1'b1;
  end

  assign bus.wr_count = cnt;
endmodule

// File: tb/tb_reg_file_16bit.sv
// Self-checking bench for reg_file_16bit: two instances (BYPASS=1 and 0)
// share the same stimulus; a behavioural array model predicts every read.
module tb_reg_file_16bit;
  import reg_file_16bit_pkg::*;

  logic        clk;
  logic        rst_n_t;
  logic        we_t;
  logic [2:0]  waddr_t, ra_t, rb_t;
  logic [15:0] wdata_t;

  int tests = 0;
  int fails = 0;

  logic [15:0] mdl [8];
  int          cnt_m;

  reg_file_16bit_if i1 ();
  reg_file_16bit_if i0 ();

  assign i1.we = we_t;  assign i1.waddr = waddr_t;  assign i1.wdata = wdata_t;
  assign i1.raddr_a = ra_t;  assign i1.raddr_b = rb_t;
  assign i0.we = we_t;  assign i0.waddr = waddr_t;  assign i0.wdata = wdata_t;
  assign i0.raddr_a = ra_t;  assign i0.raddr_b = rb_t;

  reg_file_16bit #(.BYPASS(1'b1)) u_byp (.clk(clk), .rst_n(rst_n_t), .bus(i1));
  reg_file_16bit #(.BYPASS(1'b0)) u_nob (.clk(clk), .rst_n(rst_n_t), .bus(i0));

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_rd(input logic [2:0] a, input bit byp);
    if (!rst_n_t || a == 3'd0) return 16'h0000;
    if (byp && we_t && waddr_t != 3'd0 && waddr_t == a) return wdata_t;
    return mdl[a];
  endfunction

  function automatic logic [15:0] exp_cnt();
    return 16'(cnt_m);
  endfunction

  task automatic check_all(input string ph);
    chk({ph, "_b1_a"}, i1.rdata_a, exp_rd(ra_t, 1'b1));
    chk({ph, "_b1_b"}, i1.rdata_b, exp_rd(rb_t, 1'b1));
    chk({ph, "_b0_a"}, i0.rdata_a, exp_rd(ra_t, 1'b0));
    chk({ph, "_b0_b"}, i0.rdata_b, exp_rd(rb_t, 1'b0));
    chk({ph, "_cnt1"}, {8'h00, i1.wr_count}, exp_cnt());
    chk({ph, "_cnt0"}, {8'h00, i0.wr_count}, exp_cnt());
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;
    cnt_m = 0;
  endtask

  task automatic commit();
    if (rst_n_t && we_t && waddr_t != 3'd0) begin
      mdl[waddr_t] = wdata_t;
      if (cnt_m < 255) cnt_m++;
    end
  endtask

  // One cycle: drive after negedge, check before and after the rising edge.
  task automatic step(input logic w, input logic [2:0] wa, input logic [15:0] wd,
                      input logic [2:0] a, input logic [2:0] b, input string ph);
    @(negedge clk);
    we_t = w; waddr_t = wa; wdata_t = wd; ra_t = a; rb_t = b;
    #1 check_all({ph, "_pre"});
    @(posedge clk);
    commit();
    #1 check_all({ph, "_post"});
  endtask

  logic [15:0] mux_out;
  opsel_e      sel;
  logic [7:0]  imm8;

  initial begin
    rst_n_t = 1'b0; we_t = 1'b0; waddr_t = 3'd0; wdata_t = 16'h0000; ra_t = 3'd0; rb_t = 3'd0;
    model_reset();

    // Reset: low for 15 ns with the clock running; a write held meanwhile must not leak.
    #2 we_t = 1'b1; waddr_t = 3'd2; wdata_t = 16'hDEAD; ra_t = 3'd2; rb_t = 3'd2;
    #1 chk("rst_byp_a", i1.rdata_a, 16'h0000);
    chk("rst_byp_b", i1.rdata_b, 16'h0000);
    #12 rst_n_t = 1'b1; we_t = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ra_t = 3'(i); rb_t = 3'(7 - i);
      #1 chk("rst_rd_a", i1.rdata_a, 16'h0000);
      chk("rst_rd_b", i0.rdata_b, 16'h0000);
    end
    chk("rst_cnt", {8'h00, i1.wr_count}, 16'h0000);

    // Basic write/read.
    step(1'b1, 3'd3, 16'h0010, 3'd0, 3'd0, "w3");
    step(1'b1, 3'd5, 16'h0017, 3'd0, 3'd0, "w5");
    step(1'b0, 3'd0, 16'h0000, 3'd3, 3'd5, "rd35");
    chk("basic_a", i1.rdata_a, 16'h0010);
    chk("basic_b", i1.rdata_b, 16'h0017);
    chk("basic_cnt", {8'h00, i1.wr_count}, 16'h0002);
    imm8 = 8'hF3;
    sel = SEL_REG;
    mux_out = (sel == SEL_REG) ? i1.rdata_b : sext8(imm8);
    chk("mux_x", mux_out, 16'h0017);
    sel = SEL_IMM;
    mux_out = (sel == SEL_REG) ? i1.rdata_b : sext8(imm8);
    chk("mux_y", mux_out, 16'hFFF3);

    // R0 protection.
    step(1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd0, "r0");
    chk("r0_a", i1.rdata_a, 16'h0000);
    chk("r0_cnt", {8'h00, i1.wr_count}, 16'h0002);

    // Bypass: R2=1234, then write BEEF with both ports on R2.
    step(1'b1, 3'd2, 16'h1234, 3'd0, 3'd0, "w2");
    @(negedge clk);
    we_t = 1'b1; waddr_t = 3'd2; wdata_t = 16'hBEEF; ra_t = 3'd2; rb_t = 3'd2;
    #1 chk("byp1_a_pre", i1.rdata_a, 16'hBEEF);
    chk("byp1_b_pre", i1.rdata_b, 16'hBEEF);
    chk("byp0_a_pre", i0.rdata_a, 16'h1234);
    chk("byp0_b_pre", i0.rdata_b, 16'h1234);
    @(posedge clk);
    commit();
    #1 chk("byp1_a_post", i1.rdata_a, 16'hBEEF);
    chk("byp0_a_post", i0.rdata_a, 16'hBEEF);
    chk("byp0_b_post", i0.rdata_b, 16'hBEEF);

    // Async reset mid-write: pull reset 2 ns before the capturing edge.
    step(1'b1, 3'd4, 16'h00AA, 3'd4, 3'd4, "w4");
    @(negedge clk);
    we_t = 1'b1; waddr_t = 3'd4; wdata_t = 16'h5555; ra_t = 3'd4; rb_t = 3'd4;
    #3 rst_n_t = 1'b0;
    model_reset();
    #1 chk("mid_a_imm", i1.rdata_a, 16'h0000);
    chk("mid_b_imm", i0.rdata_b, 16'h0000);
    @(posedge clk);
    #1 check_all("mid_edge");
    @(negedge clk);
    rst_n_t = 1'b1; we_t = 1'b0;
    #1 chk("mid_r4_after", i1.rdata_a, 16'h0000);
    chk("mid_r4_after0", i0.rdata_a, 16'h0000);
    chk("mid_cnt", {8'h00, i1.wr_count}, 16'h0000);

    // Randomised traffic against the model.
    for (int n = 0; n < 300; n++) begin
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), "rnd");
    end

    // Saturation: 260 writes to R1 starting from a fresh count.
    @(negedge clk);
    rst_n_t = 1'b0; we_t = 1'b0;
    model_reset();
    #2 rst_n_t = 1'b1;
    for (int n = 0; n < 260; n++) step(1'b1, 3'd1, 16'(n), 3'd1, 3'd0, "sat");
    step(1'b0, 3'd0, 16'h0000, 3'd1, 3'd1, "sat_rd");
    chk("sat_cnt1", {8'h00, i1.wr_count}, 16'h00FF);
    chk("sat_cnt0", {8'h00, i0.wr_count}, 16'h00FF);
    chk("sat_r1", i1.rdata_a, 16'h0103);
    chk("sat_r1_0", i0.rdata_b, 16'h0103);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/reg_file_16bit.md
Name: reg_file_16bit

Overview:
- 8-entry x 16-bit general-purpose register file for the single-cycle datapath.
- Sits directly upstream of the 16-bit operand-select mux: read port A feeds the ALU A operand, and read port B feeds the mux X input (mux Y is the sign-extended immediate).
- Two combinational read ports, one synchronous write port.
- R0 is hardwired to zero.

Parameters:
- DATA_W, 16, register and port data width.
- ADDR_W, 3, register address width; NUM_REGS = 2**ADDR_W = 8.
- BYPASS, 1, when 1 a same-cycle write is forwarded to a matching read port; when 0 reads return the stored value only.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- we  in  1  write enable, sampled on the rising clk edge.
- waddr  in  ADDR_W  write register index.
- wdata  in  DATA_W  write data.
- raddr_a  in  ADDR_W  read port A index.
- raddr_b  in  ADDR_W  read port B index.
- rdata_a  out  DATA_W  read port A data (combinational).
- rdata_b  out  DATA_W  read port B data (combinational); drives the mux X input.
- wr_count  out  8  saturating count of committed writes, a debug/verification aid.

Behaviour:
- Reset:
  - rst_n low clears R1..R7 to 16'h0000 and wr_count to 0 immediately, without waiting for clk.
  - While rst_n is low, rdata_a and rdata_b read 0 for any address, and BYPASS is suppressed.
- Reset mid-operation: asserting rst_n during a cycle with we=1 discards that write. Deassertion is treated as synchronous to clk by the caller; the first capturable edge is the first rising edge with rst_n high.
- Write:
  - On a rising clk edge with rst_n=1, we=1 and waddr!=0, R[waddr] <= wdata.
  - Writes to waddr=0 are ignored: R0 stays 0 and wr_count does not increment.
- wr_count:
  - Increments by 1 on each committed write (we=1, waddr!=0, rst_n=1).
  - Saturates at 8'hFF and never wraps to 0.
- Read:
  - rdata_x = R[raddr_x], combinational from the address and the stored state, with zero-cycle latency.
  - raddr_x=0 always returns 0, regardless of we, waddr or BYPASS.
- Bypass (BYPASS=1): if we=1, waddr!=0 and raddr_x==waddr in the same cycle, rdata_x = wdata before the edge. After the edge the stored value equals wdata, so the output stays stable.
- No bypass (BYPASS=0): in the same situation, rdata_x shows the old value until the edge, then the new value.
- Simultaneous events:
  - Both read ports may address the same register, and each returns identical data.
  - Both read ports may match waddr; both are then bypassed.
  - With only one write port, write-write collisions cannot occur.
- Arithmetic: no arithmetic on data. wdata is stored bit-exact; there is no sign handling or truncation (widths match).
- X handling: if we=1 and waddr contains X/Z, the simulation model may flag an error. The RTL behaviour is then undefined, and the bench must not drive this.

Decomposition:
- Shared package/header `datapath_defs`:
  - DATA_W=16 and ADDR_W=3.
  - Register index constants REG_ZERO=0 .. R7=7.
  - The mux select encoding (SEL_REG=0, SEL_IMM=1) that this block's consumer uses.
- One natural sub-module: `reg16_en`, a DATA_W-bit register with asynchronous active-low clear and a synchronous load enable.
  - Instantiate it 7 times (R1..R7) under a generate loop, with the enable decoded from we and waddr.
  - The read muxes, bypass compare and wr_count stay in the top module.

Test Plan:
- Reset: pulse rst_n low for 15 ns with clk running, then release; read all 8 addresses on both ports -> every rdata = 16'h0000 and wr_count = 0.
- Basic write/read:
  - Stimulus: write R3=16'h0010 and R5=16'h0017 on consecutive edges, then set raddr_a=3 and raddr_b=5.
  - Response: rdata_a=16'h0010, rdata_b=16'h0017, wr_count=2.
  - Mux check: feed rdata_b to the mux X input and toggle select -> mux output = 16'h0017 when select=0.
- R0 protection: we=1, waddr=0, wdata=16'hFFFF, then an edge, with raddr_a=0 -> rdata_a=0 before and after the edge; wr_count unchanged.
- Bypass:
  - Stimulus: with R2 holding 16'h1234, set we=1, waddr=2, wdata=16'hBEEF and raddr_a=raddr_b=2, then sample before the edge.
  - BYPASS=1: both ports read 16'hBEEF.
  - BYPASS=0: both ports read 16'h1234 before the edge and 16'hBEEF after it.
- Async reset mid-write:
  - Stimulus: R4=16'h00AA is stored; drive we=1, waddr=4, wdata=16'h5555, then pull rst_n low 2 ns before the edge.
  - Response: rdata for R4 = 0 immediately; after release R4 = 0, not 16'h5555.
- wr_count saturation: perform 260 writes to R1 with incrementing data -> wr_count=8'hFF (not 8'h04); R1 = the last data written, 16'h0103 when data starts at 0.
